// File: rtl/ssd_pkg.sv
// Shared definitions for the four-digit display arbiter: active-low segment
// patterns {g,f,e,d,c,b,a} and the arbiter FSM state type.
package ssd_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;

   typedef enum logic {
      IDLE,
      SHOW
   } state_e;

endpackage

// File: rtl/hex2seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex2seg
   import ssd_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   always_comb begin
      // NOTE: assign a default before the case so no path leaves seg_o unassigned (latch).
      seg_o = SEG_BLANK;
      unique case (nibble_i)
         4'h0: seg_o = SEG_0;
         4'h1: seg_o = SEG_1;
         4'h2: seg_o = SEG_2;
         4'h3: seg_o = SEG_3;
         4'h4: seg_o = SEG_4;
         4'h5: seg_o = SEG_5;
         4'h6: seg_o = SEG_6;
         4'h7: seg_o = SEG_7;
         4'h8: seg_o = SEG_8;
         4'h9: seg_o = SEG_9;
         4'hA: seg_o = SEG_A;
         4'hB: seg_o = SEG_B;
         4'hC: seg_o = SEG_C;
         4'hD: seg_o = SEG_D;
         4'hE: seg_o = SEG_E;
         4'hF: seg_o = SEG_F;
      endcase
   end

endmodule

// File: rtl/ssd_arbiter.sv
// Round-robin arbiter sharing one four-digit display among NREQ requesters.
// Define SSD_ARBITER_LZB_EN to blank leading zero digits (seg0 always shown).
module ssd_arbiter
   import ssd_pkg::*;
#(
   parameter int NREQ  = 3,
   parameter int DWELL = 50000000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [16*NREQ-1:0]   data,
   output logic [6:0]           seg0,
   output logic [6:0]           seg1,
   output logic [6:0]           seg2,
   output logic [6:0]           seg3,
   output logic [NREQ-1:0]      gnt,
   output logic                 busy
);

   localparam int              IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int              CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0]   CNT_MAX  = CW'(DWELL - 1);
   localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);

   state_e               state_q, state_d;
   logic [NREQ-1:0]      gnt_q, gnt_d;
   logic [IW-1:0]        last_q, last_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [3:0][6:0]      seg_q, seg_d;

   logic [IW:0]          pick_any, pick_other;
   logic [15:0]          sel_data;
   logic [3:0][6:0]      dec, shown;

   // Returns {found, index}; nearest requester after 'last' wins.
   function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] cand,
                                          input logic [IW-1:0]   last);
      logic [IW:0] pick;
      int          idx;
      pick = '0;
      for (int i = NREQ; i >= 1; i--) begin
         idx = (int'(last) + i) % NREQ;
         if (cand[IW'(idx)]) pick = {1'b1, IW'(idx)};
      end
      return pick;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
      logic [NREQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

   assign pick_any   = rr_pick(req, last_q);
   assign pick_other = rr_pick(req & ~gnt_q, last_q);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (pick_any[IW]) begin
               state_d = SHOW;
               gnt_d   = onehot(pick_any[IW-1:0]);
               last_d  = pick_any[IW-1:0];
               cnt_d   = '0;
            end
         end
         SHOW: begin
            // A dropped request always wins over rotation, even if others wait.
            if ((req & gnt_q) == '0) begin
               state_d = IDLE;
               gnt_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               if (pick_other[IW]) begin
                  gnt_d  = onehot(pick_other[IW-1:0]);
                  last_d = pick_other[IW-1:0];
                  cnt_d  = '0;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      endcase
   end

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_q[i]) sel_data = data[16*i +: 16];
      end
   end

   hex2seg u_hex0 (.nibble_i(sel_data[3:0]),   .seg_o(dec[0]));
   hex2seg u_hex1 (.nibble_i(sel_data[7:4]),   .seg_o(dec[1]));
   hex2seg u_hex2 (.nibble_i(sel_data[11:8]),  .seg_o(dec[2]));
   hex2seg u_hex3 (.nibble_i(sel_data[15:12]), .seg_o(dec[3]));

`ifdef SSD_ARBITER_LZB_EN
   always_comb begin
      shown = dec;
      if (sel_data[15:12] == 4'h0) shown[3] = SEG_BLANK;
      if (sel_data[15:8]  == 8'h0) shown[2] = SEG_BLANK;
      if (sel_data[15:4]  == 12'h0) shown[1] = SEG_BLANK;
   end
`else
   assign shown = dec;
`endif

   // Segments trail gnt by one cycle, so they blank one edge after a drop.
   assign seg_d = (|gnt_q) ? shown : {4{SEG_BLANK}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         last_q  <= LAST_RST;
         cnt_q   <= '0;
         seg_q   <= {4{SEG_BLANK}};
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         seg_q   <= seg_d;
      end
   end

   assign gnt  = gnt_q;
   assign busy = |gnt_q;
   assign seg0 = seg_q[0];
   assign seg1 = seg_q[1];
   assign seg2 = seg_q[2];
   assign seg3 = seg_q[3];

endmodule

// File: tb/tb_ssd_arbiter.sv
// Directed scoreboard bench for ssd_arbiter with NREQ=3, DWELL=4.
module tb_ssd_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req;
   logic [47:0] data;
   logic [6:0]  seg0, seg1, seg2, seg3;
   logic [2:0]  gnt;
   logic        busy;

   ssd_arbiter #(.NREQ(3), .DWELL(4)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .data  (data),
      .seg0  (seg0),
      .seg1  (seg1),
      .seg2  (seg2),
      .seg3  (seg3),
      .gnt   (gnt),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [2:0]  gnt;
      logic [27:0] seg;
   } exp_t;

   exp_t sb [$];
   int   n_vec = 0;
   int   n_err = 0;

   localparam logic [27:0] BLANK4 = {4{7'h7F}};

   function automatic logic [6:0] nib_seg(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   function automatic logic [27:0] exp_seg(input logic [15:0] d);
      logic [6:0] s3, s2, s1, s0;
      s3 = nib_seg(d[15:12]);
      s2 = nib_seg(d[11:8]);
      s1 = nib_seg(d[7:4]);
      s0 = nib_seg(d[3:0]);
`ifdef SSD_ARBITER_LZB_EN
      if (d[15:12] == 4'h0) s3 = 7'h7F;
      if (d[15:8]  == 8'h0) s2 = 7'h7F;
      if (d[15:4]  == 12'h0) s1 = 7'h7F;
`endif
      return {s3, s2, s1, s0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [2:0] g, input logic [27:0] s);
      exp_t e;
      e.tag = tag;
      e.gnt = g;
      e.seg = s;
      sb.push_back(e);
   endtask

   task automatic compare_out();
      exp_t        e;
      logic [27:0] seg_obs;
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $error("FAIL scoreboard: observed empty queue, expected a pending entry");
         return;
      end
      e       = sb.pop_front();
      seg_obs = {seg3, seg2, seg1, seg0};
      n_vec++;
      assert (gnt === e.gnt) else begin
         n_err++;
         $error("FAIL %s gnt: observed %b expected %b", e.tag, gnt, e.gnt);
      end
      n_vec++;
      assert (busy === (|e.gnt)) else begin
         n_err++;
         $error("FAIL %s busy: observed %b expected %b", e.tag, busy, |e.gnt);
      end
      n_vec++;
      assert (seg_obs === e.seg) else begin
         n_err++;
         $error("FAIL %s seg3..0: observed %h expected %h", e.tag, seg_obs, e.seg);
      end
   endtask

   task automatic pulse_reset();
      req   = 3'b000;
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Steady rotation among the lowest nact requesters, all held high.
   task automatic run_rotation(input string tag, input int nact, input int ticks);
      logic [2:0]  g;
      logic [27:0] s;
      int          p;
      for (int k = 1; k <= ticks; k++) begin
         g = 3'(1 << (((k - 1) / 4) % nact));
         if (k == 1) begin
            s = BLANK4;
         end else begin
            p = ((k - 2) / 4) % nact;
            s = exp_seg(data[16*p +: 16]);
         end
         expect_out($sformatf("%s_t%0d", tag, k), g, s);
      end
      for (int k = 1; k <= ticks; k++) begin
         tick();
         compare_out();
      end
   endtask

   initial begin
      reset = 1'b1;
      req   = 3'b000;
      data  = {16'h0F07, 16'hABCD, 16'h1234};
      tick();
      tick();
      expect_out("reset", 3'b000, BLANK4);
      compare_out();

      reset = 1'b0;
      tick();
      expect_out("idle", 3'b000, BLANK4);
      compare_out();

      // Single requester: grant one edge later, digits the edge after, then hold.
      req = 3'b001;
      expect_out("grant0", 3'b001, BLANK4);
      expect_out("digits0", 3'b001, {7'h79, 7'h24, 7'h30, 7'h19});
      tick();
      compare_out();
      tick();
      compare_out();
      repeat (4) tick();
      expect_out("hold0", 3'b001, {7'h79, 7'h24, 7'h30, 7'h19});
      compare_out();

      data[15:0] = 16'h0005;
`ifdef SSD_ARBITER_LZB_EN
      expect_out("d0005", 3'b001, {7'h7F, 7'h7F, 7'h7F, 7'h12});
`else
      expect_out("d0005", 3'b001, {7'h40, 7'h40, 7'h40, 7'h12});
`endif
      tick();
      compare_out();

      data[15:0] = 16'h0000;
`ifdef SSD_ARBITER_LZB_EN
      expect_out("d0000", 3'b001, {7'h7F, 7'h7F, 7'h7F, 7'h40});
`else
      expect_out("d0000", 3'b001, {7'h40, 7'h40, 7'h40, 7'h40});
`endif
      tick();
      compare_out();
      data[15:0] = 16'h1234;

      // Asynchronous reset mid-cycle, then arbitration restarts at requester 0.
      req = 3'b101;
      #3 reset = 1'b1;
      #1;
      expect_out("async_rst", 3'b000, BLANK4);
      compare_out();
      tick();
      reset = 1'b0;
      expect_out("restart", 3'b001, BLANK4);
      tick();
      compare_out();

      // Granted request drops mid-dwell while another is waiting.
      pulse_reset();
      req = 3'b010;
      expect_out("drop_g1", 3'b010, BLANK4);
      expect_out("drop_d1", 3'b010, exp_seg(data[31:16]));
      tick();
      compare_out();
      tick();
      compare_out();
      req = 3'b100;
      expect_out("drop_idle", 3'b000, exp_seg(data[31:16]));
      expect_out("drop_g2", 3'b100, BLANK4);
      expect_out("drop_d2", 3'b100, exp_seg(data[47:32]));
      tick();
      compare_out();
      tick();
      compare_out();
      tick();
      compare_out();

      pulse_reset();
      req = 3'b011;
      run_rotation("rr2", 2, 13);

      pulse_reset();
      req = 3'b111;
      run_rotation("rr3", 3, 13);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
